regfile_write_arbiter: RTL and testbench

Shares the single write port of the 32x32 register file between two writeback sources, the execute-stage ALU result and the load/store unit. It arbitrates round-robin, filters writes to x0 so that x0 stays hard-wired to zero, and registers the winning write onto `rf_we`/`rf_waddr`/`rf_wdata`. It optionally tracks pending destination registers so that decode can stall on read-after-write hazards.

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_write_arbiter_rr_arbiter2.sv | 18 +
 rtl/regfile_write_arbiter.sv | 81 ++++++++
 tb/tb_regfile_write_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths and types for the register-file writeback path
package regfile_pkg;
   localparam int XLEN   = 32;
   localparam int NREG   = 32;
   localparam int REG_AW = $clog2(NREG);
   typedef enum logic {WB_ALU = 1'b0, WB_LSU = 1'b1} wb_src_e;
   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   data;
   } wb_req_t;
endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-requester round-robin arbiter; bit 0 = ALU, bit 1 = LSU
module rr_arbiter2
   import regfile_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req_i,
   input  logic       accept_i,
   output logic [1:0] gnt_o
);
   wb_src_e last_q, last_d;
   assign gnt_o[0] = req_i[0] & (~req_i[1] | (last_q == WB_LSU));
   assign gnt_o[1] = req_i[1] & (~req_i[0] | (last_q == WB_ALU));
   assign last_d   = accept_i ? (gnt_o[0] ? WB_ALU : WB_LSU) : last_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) last_q <= WB_LSU;
      else        last_q <= last_d;
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register-file write port between ALU and LSU,
// drops x0 writes; pending-write scoreboard built only with RF_SCOREBOARD_EN.
module regfile_write_arbiter
   import regfile_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [REG_AW-1:0] alu_rd,
   input  logic [XLEN-1:0]   alu_data,
   input  logic              lsu_valid,
   output logic              lsu_ready,
   input  logic [REG_AW-1:0] lsu_rd,
   input  logic [XLEN-1:0]   lsu_data,
   output logic              rf_we,
   output logic [REG_AW-1:0] rf_waddr,
   output logic [XLEN-1:0]   rf_wdata,
   input  logic              issue_valid,
   input  logic [REG_AW-1:0] issue_rd,
   input  logic [REG_AW-1:0] rs1,
   input  logic [REG_AW-1:0] rs2,
   output logic              hazard,
   input  logic              flush
);
   wb_req_t           alu_req, lsu_req;
   logic [1:0]        req, gnt;
   logic              we_d, we_q;
   logic [REG_AW-1:0] waddr_d, waddr_q;
   logic [XLEN-1:0]   wdata_d, wdata_q;
   assign alu_req = {alu_valid, alu_rd, alu_data};
   assign lsu_req = {lsu_valid, lsu_rd, lsu_data};
   // x0 requests never reach the arbiter and are always accepted
   assign req = {lsu_req.valid & (lsu_req.rd != '0), alu_req.valid & (alu_req.rd != '0)};
   assign alu_ready = (alu_req.rd == '0) | gnt[0];
   assign lsu_ready = (lsu_req.rd == '0) | gnt[1];
   rr_arbiter2 u_arb (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_i    (req),
      .accept_i (|gnt),
      .gnt_o    (gnt)
   );
   always_comb begin
      we_d    = |gnt;
      waddr_d = gnt[0] ? alu_req.rd : gnt[1] ? lsu_req.rd : waddr_q;
      wdata_d = gnt[0] ? alu_req.data : gnt[1] ? lsu_req.data : wdata_q;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
      end
   assign rf_we    = we_q;
   assign rf_waddr = waddr_q;
   assign rf_wdata = wdata_q;
`ifdef RF_SCOREBOARD_EN
   logic [NREG-1:0] busy_q, busy_d;
   // busy clears on the commit edge; a same-index issue overrides the clear
   always_comb begin
      busy_d = busy_q;
      if (we_q) busy_d[waddr_q] = 1'b0;
      if (issue_valid) busy_d[issue_rd] = 1'b1;
      busy_d[0] = 1'b0;
      if (flush) busy_d = '0;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) busy_q <= '0;
      else        busy_q <= busy_d;
   assign hazard = busy_q[rs1] | busy_q[rs2] | (issue_valid & busy_q[issue_rd]);
`else
   logic unused_sb;
   assign unused_sb = ^{issue_valid, issue_rd, rs1, rs2, flush};
   assign hazard    = 1'b0;
`endif
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: scoreboard bench; expected writes queued at grant, popped on rf_we
module tb_regfile_write_arbiter;
   logic        clk, rst_n;
   logic        alu_valid, alu_ready, lsu_valid, lsu_ready;
   logic [4:0]  alu_rd, lsu_rd, rf_waddr, issue_rd, rs1, rs2;
   logic [31:0] alu_data, lsu_data, rf_wdata;
   logic        rf_we, issue_valid, hazard, flush;
   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;
   wr_t  exp_q[$];
   logic tb_last;
   int   n_chk, n_fail;
   regfile_write_arbiter dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .alu_valid   (alu_valid),
      .alu_ready   (alu_ready),
      .alu_rd      (alu_rd),
      .alu_data    (alu_data),
      .lsu_valid   (lsu_valid),
      .lsu_ready   (lsu_ready),
      .lsu_rd      (lsu_rd),
      .lsu_data    (lsu_data),
      .rf_we       (rf_we),
      .rf_waddr    (rf_waddr),
      .rf_wdata    (rf_wdata),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .rs1         (rs1),
      .rs2         (rs2),
      .hazard      (hazard),
      .flush       (flush)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   // one cycle of stimulus; the bench predicts the grant and queues the write
   task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                        output logic a_acc, output logic l_acc);
      logic an, ln, ga, gl;
      wr_t  w;
      alu_valid = av; alu_rd = ard; alu_data = ad;
      lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
      #1;
      an = av && (ard != 0);
      ln = lv && (lrd != 0);
      ga = an && (!ln || tb_last);
      gl = ln && (!an || !tb_last);
      check("alu_ready", alu_ready, ga || (ard == 0));
      check("lsu_ready", lsu_ready, gl || (lrd == 0));
      if (ga) begin
         w.addr = ard; w.data = ad; exp_q.push_back(w); tb_last = 1'b0;
      end else if (gl) begin
         w.addr = lrd; w.data = ld; exp_q.push_back(w); tb_last = 1'b1;
      end
      cyc();
      check("rf_we", rf_we, ga || gl);
      a_acc = av && (ga || (ard == 0));
      l_acc = lv && (gl || (lrd == 0));
   endtask
   always @(negedge clk)
      if (rst_n && rf_we) begin
         if (exp_q.size() == 0) check("extra_write", 1, 0);
         else begin
            wr_t e;
            e = exp_q.pop_front();
            check("rf_waddr", rf_waddr, e.addr);
            check("rf_wdata", rf_wdata, e.data);
         end
      end
   initial begin
      logic a_acc, l_acc, a_v, l_v;
      logic [4:0]  a_rd, l_rd;
      logic [31:0] a_d, l_d;
      n_chk = 0; n_fail = 0; tb_last = 1'b1;
      rst_n = 1'b0;
      alu_valid = 0; alu_rd = 0; alu_data = 0;
      lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
      issue_valid = 0; issue_rd = 0; rs1 = 0; rs2 = 0; flush = 0;
      #2;
      check("rst_we", rf_we, 0);
      check("rst_waddr", rf_waddr, 0);
      check("rst_wdata", rf_wdata, 0);
      check("rst_hazard", hazard, 0);
      cyc();
      rst_n = 1'b1;
      // tie: ALU wins first, LSU held then granted
      drive(1, 3, 32'h11, 1, 4, 32'h22, a_acc, l_acc);
      drive(0, 0, 0, 1, 4, 32'h22, a_acc, l_acc);
      drive(0, 0, 0, 0, 0, 0, a_acc, l_acc);
      // x0 write is swallowed
      drive(1, 0, 32'hDEAD, 1, 5, 32'h7, a_acc, l_acc);
      drive(0, 0, 0, 0, 0, 0, a_acc, l_acc);
      // random traffic with backpressure hold
      a_v = 0; l_v = 0; a_rd = 0; l_rd = 0; a_d = 0; l_d = 0;
      a_acc = 1; l_acc = 1;
      for (int i = 0; i < 80; i++) begin
         if (!a_v || a_acc) begin
            a_v = 1'($urandom_range(0, 1));
            a_rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            a_d = $urandom;
         end
         if (!l_v || l_acc) begin
            l_v = 1'($urandom_range(0, 1));
            l_rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            l_d = $urandom;
         end
         drive(a_v, a_rd, a_d, l_v, l_rd, l_d, a_acc, l_acc);
      end
      drive(0, 0, 0, 0, 0, 0, a_acc, l_acc);
      // reset mid-write drops the registered write and restores last = LSU
      drive(1, 9, 32'h99, 0, 0, 0, a_acc, l_acc);
      alu_valid = 0; alu_rd = 0;
      rst_n = 1'b0;
      #1;
      check("mid_rst_we", rf_we, 0);
      check("mid_rst_waddr", rf_waddr, 0);
      check("mid_rst_wdata", rf_wdata, 0);
      check("mid_rst_hazard", hazard, 0);
      void'(exp_q.pop_back());
      tb_last = 1'b1;
      cyc();
      rst_n = 1'b1;
      drive(1, 6, 32'h66, 1, 8, 32'h88, a_acc, l_acc);
      drive(0, 0, 0, 1, 8, 32'h88, a_acc, l_acc);
      drive(0, 0, 0, 0, 0, 0, a_acc, l_acc);
`ifdef RF_SCOREBOARD_EN
      issue_valid = 1; issue_rd = 7;
      cyc();
      issue_valid = 0; rs1 = 7; #1;
      check("hz_rs1", hazard, 1);
      rs1 = 0; rs2 = 7; #1;
      check("hz_rs2", hazard, 1);
      rs2 = 0; #1;
      check("hz_none", hazard, 0);
      drive(0, 0, 0, 1, 7, 32'h77, a_acc, l_acc);
      rs1 = 7; #1;
      check("hz_hold", hazard, 1);
      lsu_valid = 0; lsu_rd = 0;
      cyc();
      check("hz_clear", hazard, 0);
      rs1 = 0; issue_valid = 1; issue_rd = 7;
      cyc();
      issue_valid = 0;
      drive(0, 0, 0, 1, 7, 32'h78, a_acc, l_acc);
      lsu_valid = 0; lsu_rd = 0;
      issue_valid = 1; issue_rd = 7;
      cyc();
      issue_valid = 0; rs1 = 7; #1;
      check("hz_collide", hazard, 1);
      rs1 = 0; issue_valid = 1; issue_rd = 2;
      cyc();
      issue_rd = 9;
      cyc();
      issue_valid = 0; rs1 = 2; rs2 = 9; #1;
      check("hz_2_9", hazard, 1);
      rs1 = 0; rs2 = 0; issue_valid = 1; issue_rd = 9; #1;
      check("hz_issue", hazard, 1);
      flush = 1; issue_rd = 2;
      cyc();
      flush = 0; issue_valid = 0; rs1 = 2; rs2 = 9; #1;
      check("hz_flush", hazard, 0);
      rs1 = 7; rs2 = 0; #1;
      check("hz_flush7", hazard, 0);
      rs1 = 0;
`else
      issue_valid = 1; issue_rd = 7; rs1 = 7;
      cyc();
      check("hz_off", hazard, 0);
      issue_valid = 0; rs1 = 0;
`endif
      drive(0, 0, 0, 0, 0, 0, a_acc, l_acc);
      drive(0, 0, 0, 0, 0, 0, a_acc, l_acc);
      check("sb_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
